ex_mem_hilo: RTL

Pipeline register between the EX stage (ALU + divider) and the MEM stage. It also owns the architectural HI/LO register pair. It latches the ALU result, the HI/LO update and overflow status each cycle. It turns a divider stall into a MEM-stage bubble and commits HI/LO when the instruction leaves MEM. It returns the current (optionally forwarded) HI/LO value to the ALU's `hilo_in`.

---
 rtl/ex_mem_hilo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ex_mem_hilo.sv
// ============================================================================
//  Module      : ex_mem_hilo
//  Description : EX->MEM pipeline register that also owns the architectural
//                HI/LO register pair. Captures ALU result, pending HI/LO
//                update and overflow status; turns a divider stall into a
//                MEM-stage bubble; commits HI/LO when the instruction retires
//                from MEM. Build option: define HILO_FWD_EN to forward the
//                pending MEM-stage HI/LO halves onto hilo_in (hilo_busy then
//                reads 0); otherwise hilo_in is architectural only and
//                hilo_busy flags the hazard to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_hilo #(
    parameter logic [63:0] RESET_HILO = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_y,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic [63:0] ex_hilo,
    input  logic [1:0]  ex_hilo_we,
    input  logic        ex_overflow,
    input  logic        ex_stall_div,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        mem_valid,
    output logic [31:0] mem_y,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_we,
    output logic        exc_ov,
    output logic [63:0] hilo_in,
    output logic        hilo_busy,
    output logic        stall_ex
);

    // MEM-stage state
    logic        r_mem_valid;
    logic [31:0] r_mem_y;
    logic [4:0]  r_mem_rd;
    logic        r_mem_reg_we;
    logic [63:0] r_pend_hilo;
    logic [1:0]  r_pend_we;
    logic        r_ov;

    // Architectural HI (63:32) / LO (31:0)
    logic [63:0] r_hilo;

    // Instruction leaves MEM this cycle and is not being killed
    logic        w_commit;

    assign w_commit = r_mem_valid & ~mem_stall & ~flush;

    // Stage register: rst > flush > mem_stall (hold) > div stall (bubble) > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid  <= 1'b0;
            r_mem_y      <= 32'h0;
            r_mem_rd     <= 5'h0;
            r_mem_reg_we <= 1'b0;
            r_pend_hilo  <= 64'h0;
            r_pend_we    <= 2'b00;
            r_ov         <= 1'b0;
        end else if (flush) begin
            r_mem_valid  <= 1'b0;
            r_mem_reg_we <= 1'b0;
            r_pend_we    <= 2'b00;
            r_ov         <= 1'b0;
        end else if (mem_stall) begin
            // hold every MEM field
        end else if (ex_stall_div) begin
            // Divider not done: send a bubble; data fields are don't-care
            r_mem_valid  <= 1'b0;
            r_mem_reg_we <= 1'b0;
            r_pend_we    <= 2'b00;
            r_ov         <= 1'b0;
        end else begin
            // An overflowing instruction must not write any architectural state
            r_mem_valid  <= ex_valid;
            r_mem_y      <= ex_y;
            r_mem_rd     <= ex_rd;
            r_mem_reg_we <= ex_reg_we & ~ex_overflow;
            r_pend_hilo  <= ex_hilo;
            r_pend_we    <= ex_overflow ? 2'b00 : ex_hilo_we;
            r_ov         <= ex_overflow;
        end
    end

    // HI/LO commit on retirement, per half
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hilo <= RESET_HILO;
        end else if (w_commit) begin
            if (r_pend_we[1]) begin
                r_hilo[63:32] <= r_pend_hilo[63:32];
            end
            if (r_pend_we[0]) begin
                r_hilo[31:0] <= r_pend_hilo[31:0];
            end
        end
    end

    assign mem_valid  = r_mem_valid;
    assign mem_y      = r_mem_y;
    assign mem_rd     = r_mem_rd;
    assign mem_reg_we = r_mem_reg_we;

    // Held low while MEM is stalled so the exception is raised exactly once
    assign exc_ov   = r_mem_valid & r_ov & ~mem_stall;

    assign stall_ex = ex_stall_div | mem_stall;

`ifdef HILO_FWD_EN
    // Merge the in-flight MEM-stage write per half so a reader sees it at once
    assign hilo_in[63:32] = (r_mem_valid & r_pend_we[1]) ? r_pend_hilo[63:32] : r_hilo[63:32];
    assign hilo_in[31:0]  = (r_mem_valid & r_pend_we[0]) ? r_pend_hilo[31:0]  : r_hilo[31:0];
    assign hilo_busy      = 1'b0;
`else
    // No bypass: decode must stall HI/LO readers while a write is in MEM
    assign hilo_in   = r_hilo;
    assign hilo_busy = r_mem_valid & (|r_pend_we);
`endif

endmodule

`default_nettype wire
